// File: rtl/truth_table_sequencer_pkg.sv
// Shared types and constants for the truth-table self-test sequencer.
package truth_table_pkg;

  localparam int         VEC_W     = 3;
  localparam logic [7:0] SILLY_EXP = 8'h31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/truth_table_sequencer_if.sv
// Control, stimulus and result signals between a test host and the sequencer.
interface truth_table_sequencer_if;
  import truth_table_pkg::*;

  logic             start;
  logic             abort;
  logic [VEC_W-1:0] dut_in;
  logic             dut_y;
  logic             busy;
  logic             done;
  logic             pass;
  logic [3:0]       err_count;
  logic [7:0]       captured;

  modport master (
    output start, abort, dut_y,
    input  dut_in, busy, done, pass, err_count, captured
  );

  modport slave (
    input  start, abort, dut_y,
    output dut_in, busy, done, pass, err_count, captured
  );

endinterface

// File: rtl/truth_table_sequencer_dwell_timer.sv
// 8-bit dwell counter; expire marks the last cycle a vector is held.
module dwell_timer #(
  parameter int unsigned DWELL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic expire
);

  localparam logic [7:0] LAST = 8'(DWELL - 1);

  logic [7:0] r_cnt;

  assign expire = (r_cnt == LAST);

  // NOTE: state is written with <= only, so every register sees pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= expire ? '0 : r_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/truth_table_sequencer.sv
// Sweeps all input vectors through the function block, compares against a golden table.
module truth_table_sequencer
  import truth_table_pkg::*;
#(
  parameter int unsigned DWELL     = 4,
  parameter logic [7:0]  EXP_TABLE = SILLY_EXP
) (
  input logic                    clk,
  input logic                    rst_n,
  truth_table_sequencer_if.slave bus
);

  state_t           r_state;
  logic [VEC_W-1:0] r_index;
  logic [VEC_W-1:0] r_dut_in;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [3:0]       r_err;
  logic [7:0]       r_captured;

  logic       w_in_run;
  logic       w_expire;
  logic       w_mismatch;
  logic [3:0] w_err_next;

  assign w_in_run   = (r_state == RUN);
  assign w_mismatch = (bus.dut_y != EXP_TABLE[r_index]);
  assign w_err_next = r_err + {3'b000, w_mismatch};

  // Held at zero outside RUN, so a fresh sweep always starts a full dwell.
  dwell_timer #(.DWELL(DWELL)) u_dwell_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (!w_in_run || bus.abort),
    .en     (w_in_run),
    .expire (w_expire)
  );

  // NOTE: every register, results included, is cleared by the async reset so no partial sweep survives it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_index    <= '0;
      r_dut_in   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_err      <= '0;
      r_captured <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (bus.start) begin
            r_state    <= RUN;
            r_index    <= '0;
            r_dut_in   <= '0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_err      <= '0;
            r_captured <= '0;
          end
        end
        RUN: begin
          if (bus.abort) begin
            r_state  <= IDLE;
            r_dut_in <= '0;
            r_busy   <= 1'b0;
          end else if (w_expire) begin
            r_captured[r_index] <= bus.dut_y;
            r_err               <= w_err_next;
            if (r_index == {VEC_W{1'b1}}) begin
              r_state  <= DONE;
              r_dut_in <= '0;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_pass   <= (w_err_next == 4'd0);
            end else begin
              r_index  <= r_index + 1'b1;
              r_dut_in <= r_index + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.dut_in    = r_dut_in;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.pass      = r_pass;
  assign bus.err_count = r_err;
  assign bus.captured  = r_captured;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed-vector bench for truth_table_sequencer with DWELL=4 and DWELL=1 instances.
module tb_truth_table_sequencer;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   mode;   // 0 golden, 1 stuck-at-0, 2 inverted (DWELL=4 instance only)
  int   n;

  truth_table_sequencer_if if4 ();
  truth_table_sequencer_if if1 ();

  truth_table_sequencer #(.DWELL(4), .EXP_TABLE(8'h31)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if4.slave)
  );

  truth_table_sequencer #(.DWELL(1), .EXP_TABLE(8'h31)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.slave)
  );

  // y = 1 for {a,b,c} = 000, 100, 101
  function automatic logic silly(input logic [2:0] v);
    return (v[2] & ~v[1]) | (~v[2] & ~v[1] & ~v[0]);
  endfunction

  assign if4.dut_y = (mode == 1) ? 1'b0 : (mode == 2) ? ~silly(if4.dut_in) : silly(if4.dut_in);
  assign if1.dut_y = silly(if1.dut_in);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Pulse start for one edge; returns in the first RUN cycle (k+1).
  task automatic pulse_start(input bit sel1);
    @(negedge clk);
    if (sel1) if1.start = 1'b1; else if4.start = 1'b1;
    @(negedge clk);
    if1.start = 1'b0;
    if4.start = 1'b0;
  endtask

  // Called in cycle k+n0; returns the cycle offset from k at which done is seen.
  task automatic run_to_done(input bit sel1, input int n0, output int cyc);
    cyc = n0;
    while (!(sel1 ? if1.done : if4.done) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic step(input int k);
    for (int i = 0; i < k; i++) @(negedge clk);
  endtask

  initial begin
    checks = 0; failures = 0; mode = 0;
    rst_n = 1'b0;
    if4.start = 1'b0; if4.abort = 1'b0;
    if1.start = 1'b0; if1.abort = 1'b0;
    step(3);
    check("rst_busy", 32'(if4.busy), 32'd0);
    check("rst_done", 32'(if4.done), 32'd0);
    check("rst_pass", 32'(if4.pass), 32'd0);
    check("rst_err", 32'(if4.err_count), 32'd0);
    check("rst_cap", 32'(if4.captured), 32'd0);
    check("rst_in", 32'(if4.dut_in), 32'd0);
    rst_n = 1'b1;
    step(2);

    // Golden sweep, DWELL=4
    pulse_start(1'b0);
    check("g_busy", 32'(if4.busy), 32'd1);
    check("g_in0", 32'(if4.dut_in), 32'd0);
    step(3);
    check("g_cap_k4", 32'(if4.captured), 32'd0);
    step(1);
    check("g_cap_k5", 32'(if4.captured), 32'd1);
    check("g_in1", 32'(if4.dut_in), 32'd1);
    run_to_done(1'b0, 5, n);
    check("g_latency", 32'(n), 32'd33);
    check("g_cap", 32'(if4.captured), 32'h31);
    check("g_err", 32'(if4.err_count), 32'd0);
    check("g_pass", 32'(if4.pass), 32'd1);
    check("g_busy_end", 32'(if4.busy), 32'd0);
    check("g_in_end", 32'(if4.dut_in), 32'd0);

    // Stuck-at-0 output, restarted from DONE
    mode = 1;
    pulse_start(1'b0);
    check("s0_done_clr", 32'(if4.done), 32'd0);
    run_to_done(1'b0, 1, n);
    check("s0_latency", 32'(n), 32'd33);
    check("s0_cap", 32'(if4.captured), 32'h00);
    check("s0_err", 32'(if4.err_count), 32'd3);
    check("s0_pass", 32'(if4.pass), 32'd0);

    // Inverted function
    mode = 2;
    pulse_start(1'b0);
    run_to_done(1'b0, 1, n);
    check("inv_cap", 32'(if4.captured), 32'hCE);
    check("inv_err", 32'(if4.err_count), 32'd8);
    check("inv_pass", 32'(if4.pass), 32'd0);

    // Abort at edge k+10 while vector 2 is active
    mode = 0;
    pulse_start(1'b0);
    step(9);
    check("ab_in2", 32'(if4.dut_in), 32'd2);
    if4.abort = 1'b1;
    @(negedge clk);
    if4.abort = 1'b0;
    check("ab_busy", 32'(if4.busy), 32'd0);
    check("ab_in", 32'(if4.dut_in), 32'd0);
    check("ab_done", 32'(if4.done), 32'd0);
    check("ab_cap", 32'(if4.captured), 32'h01);
    check("ab_err", 32'(if4.err_count), 32'd0);
    if4.abort = 1'b1;
    step(2);
    if4.abort = 1'b0;
    check("ab_idle_ign", 32'(if4.busy), 32'd0);
    pulse_start(1'b0);
    run_to_done(1'b0, 1, n);
    check("ab_re_latency", 32'(n), 32'd33);
    check("ab_re_cap", 32'(if4.captured), 32'h31);
    check("ab_re_pass", 32'(if4.pass), 32'd1);

    // Start held high: no restart while busy, restart one cycle after done
    @(negedge clk);
    if4.start = 1'b1;
    @(negedge clk);
    run_to_done(1'b0, 1, n);
    check("hold_latency", 32'(n), 32'd33);
    @(negedge clk);
    check("hold_done_clr", 32'(if4.done), 32'd0);
    check("hold_busy", 32'(if4.busy), 32'd1);
    if4.start = 1'b0;
    run_to_done(1'b0, 1, n);
    check("hold_re_latency", 32'(n), 32'd33);
    check("hold_re_cap", 32'(if4.captured), 32'h31);

    // DWELL=1: async reset mid-sweep, then a full sweep
    pulse_start(1'b1);
    step(3);
    check("d1_cap_mid", 32'(if1.captured), 32'h01);
    check("d1_busy_mid", 32'(if1.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("d1_rst_busy", 32'(if1.busy), 32'd0);
    check("d1_rst_cap", 32'(if1.captured), 32'd0);
    check("d1_rst_in", 32'(if1.dut_in), 32'd0);
    check("d1_rst_d4done", 32'(if4.done), 32'd0);
    step(2);
    rst_n = 1'b1;
    step(1);
    pulse_start(1'b1);
    run_to_done(1'b1, 1, n);
    check("d1_latency", 32'(n), 32'd9);
    check("d1_cap", 32'(if1.captured), 32'h31);
    check("d1_err", 32'(if1.err_count), 32'd0);
    check("d1_pass", 32'(if1.pass), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
